adc_packetizer: RTL and testbench

Downstream framing stage between the two 125 MHz byte FIFOs (widthConverter outputs) and the UDP transmitter. It replaces the read controller and data mux. It selects a channel round-robin and emits one contiguous UDP payload per packet: an 8-byte header followed by PAYLOAD_BYTES sample bytes pulled from that channel's FIFO. Sequence numbering and per-channel overflow flags let the host detect dropped packets and dropped samples.

---
 rtl/adc_pkt_pkg.sv | 42 ++++
 rtl/adc_packetizer.sv | 148 ++++++++++++++
 tb/tb_adc_packetizer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkt_pkg.sv
// adc_pkt_pkg: shared types and constants for the ADC packetizer.
//   state_t      - packetizer FSM states
//   HDR_BYTES    - header length in bytes
//   CH0 / CH1    - channel identifiers carried in header byte 2
//   FLAG_OVF_BIT - overflow bit position inside the flags byte
//   hdr_byte()   - header byte selection by byte index
package adc_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int   HDR_BYTES    = 8;
    localparam logic CH0          = 1'b0;
    localparam logic CH1          = 1'b1;
    localparam int   FLAG_OVF_BIT = 0;

    // Header layout: magic (BE), channel, flags, sequence number (BE).
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [15:0] magic,
                                            input logic        ch,
                                            input logic        ovf,
                                            input logic [31:0] seq);
        logic [7:0] b;
        b = '0;
        case (idx)
            3'd0: b = magic[15:8];
            3'd1: b = magic[7:0];
            3'd2: b = {7'd0, ch};
            3'd3: b[FLAG_OVF_BIT] = ovf;
            3'd4: b = seq[31:24];
            3'd5: b = seq[23:16];
            3'd6: b = seq[15:8];
            default: b = seq[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_packetizer.sv
// adc_packetizer: frames samples from two byte FIFOs into UDP payloads.
// Channels are served round-robin; each packet is an 8-byte header followed
// by PAYLOAD_BYTES bytes read from the chosen channel's FIFO.
// Ports:
//   clk, rstn               - clock, async active-low reset
//   en                      - stream enable (level)
//   avail1/avail2           - FIFO holds at least one full payload
//   full1/full2             - FIFO full, feeds the sticky overflow flags
//   dout1/dout2, rd_en1/2   - FIFO read data (1-cycle latency) and strobes
//   udp_tx_busy             - transmitter busy, only looked at in IDLE
//   udp_tx_valid/udp_tx_data- registered payload byte stream
//   seq_num                 - sequence number of the next packet
//   active                  - header or payload on the output
//
// state | meaning
// IDLE  | wait for en, transmitter free and a channel with a full payload
// HDR   | header bytes on output, cnt counts 7..0 (byte index = 7 - cnt)
// PAY   | payload bytes on output, cnt counts PAYLOAD_BYTES-1..0
// GAP   | inter-frame idle, cnt counts IFG_CYCLES-1..0
module adc_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int          PAYLOAD_BYTES = 1024,
    parameter int          IFG_CYCLES    = 12,
    parameter logic [15:0] MAGIC         = 16'hADC0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        avail1,
    input  logic        avail2,
    input  logic        full1,
    input  logic        full2,
    input  logic [7:0]  dout1,
    input  logic [7:0]  dout2,
    output logic        rd_en1,
    output logic        rd_en2,
    input  logic        udp_tx_busy,
    output logic        udp_tx_valid,
    output logic [7:0]  udp_tx_data,
    output logic [31:0] seq_num,
    output logic        active
);

    localparam int CNT_MAX = (PAYLOAD_BYTES > IFG_CYCLES) ? PAYLOAD_BYTES : IFG_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ch;
    logic          ptr;
    logic [1:0]    ovf;
    logic [1:0]    ovf_next;
    logic [1:0]    avail_v;
    logic [1:0]    full_v;
    logic          start;
    logic          pick;
    logic          rd_active;
    logic [7:0]    dout_sel;
    logic [2:0]    hdr_idx_next;

    assign avail_v  = {avail2, avail1};
    assign full_v   = {full2, full1};
    assign start    = en && !udp_tx_busy && (avail1 || avail2);
    assign pick     = avail_v[ptr] ? ptr : ~ptr;
    assign dout_sel = (ch == CH1) ? dout2 : dout1;

    // Index of the header byte that goes out on the next edge while in HDR.
    assign hdr_idx_next = 3'(CW'(HDR_BYTES) - cnt);

    // Reads run from header byte 6 through payload byte PAYLOAD_BYTES-3 so that
    // the FIFO's one-cycle latency lines payload byte 0 up right after header byte 7.
    assign rd_active = ((state == HDR) && (cnt <= CW'(1))) ||
                       ((state == PAY) && (cnt >= CW'(2)));
    assign rd_en1    = rd_active && (ch == CH0);
    assign rd_en2    = rd_active && (ch == CH1);
    assign active    = (state == HDR) || (state == PAY);

    // Sticky overflow flags; the served channel's flag is cleared while its
    // flags byte (header byte 3, cnt == 4) is on the output, but a full in
    // that same cycle keeps it set for the next packet.
    always_comb begin
        ovf_next = ovf | full_v;
        if ((state == HDR) && (cnt == CW'(4))) begin
            ovf_next[ch] = full_v[ch];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            ch           <= CH0;
            ptr          <= CH0;
            ovf          <= '0;
            seq_num      <= '0;
            udp_tx_valid <= 1'b0;
            udp_tx_data  <= '0;
        end else begin
            ovf <= ovf_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= HDR;
                        cnt          <= CW'(HDR_BYTES - 1);
                        ch           <= pick;
                        udp_tx_valid <= 1'b1;
                        udp_tx_data  <= hdr_byte(3'd0, MAGIC, pick, 1'b0, seq_num);
                    end
                end
                HDR: begin
                    if (cnt == '0) begin
                        state       <= PAY;
                        cnt         <= CW'(PAYLOAD_BYTES - 1);
                        udp_tx_data <= dout_sel;
                    end else begin
                        cnt         <= cnt - CW'(1);
                        // Flags byte includes a full seen in this very cycle.
                        udp_tx_data <= hdr_byte(hdr_idx_next, MAGIC, ch,
                                                ovf[ch] | full_v[ch], seq_num);
                    end
                end
                PAY: begin
                    if (cnt == '0) begin
                        state        <= GAP;
                        cnt          <= CW'(IFG_CYCLES - 1);
                        udp_tx_valid <= 1'b0;
                        udp_tx_data  <= '0;
                        seq_num      <= seq_num + 32'd1;
                        ptr          <= ~ch;
                    end else begin
                        cnt         <= cnt - CW'(1);
                        udp_tx_data <= dout_sel;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_packetizer.sv
// tb_adc_packetizer: drives randomized FIFO contents, overflow pulses,
// busy hold-offs, enable drops and a mid-packet reset into adc_packetizer and
// compares every finished packet against a packet-level reference model.
module tb_adc_packetizer;

    localparam int          N    = 1024;
    localparam int          IFG  = 12;
    localparam logic [15:0] MAG  = 16'hADC0;
    localparam int          SLEN = 16384;

    logic        clk = 1'b0;
    logic        rstn, en, avail1, avail2, full1, full2, busy;
    logic [7:0]  dout1, dout2;
    logic        rd_en1, rd_en2, udp_tx_valid, active;
    logic [7:0]  udp_tx_data;
    logic [31:0] seq_num;

    always #4 clk = ~clk;

    adc_packetizer #(.PAYLOAD_BYTES(N), .IFG_CYCLES(IFG), .MAGIC(MAG)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .avail1(avail1), .avail2(avail2), .full1(full1), .full2(full2),
        .dout1(dout1), .dout2(dout2), .rd_en1(rd_en1), .rd_en2(rd_en2),
        .udp_tx_busy(busy), .udp_tx_valid(udp_tx_valid), .udp_tx_data(udp_tx_data),
        .seq_num(seq_num), .active(active)
    );

    // FIFO model: per-channel random byte stream, read with one cycle latency.
    logic [7:0] stream [2][SLEN];
    int         rp [2] = '{0, 0};

    always @(posedge clk) begin
        if (rd_en1) begin
            dout1 <= stream[0][rp[0] % SLEN];
            rp[0] = rp[0] + 1;
        end
        if (rd_en2) begin
            dout2 <= stream[1][rp[1] % SLEN];
            rp[1] = rp[1] + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference state.
    logic [7:0] pkt [$];
    bit         in_pkt    = 0;
    bit         have_prev = 0;
    int         gap       = 0;
    int         ptr_m     = 0;
    int         cur_ch    = 0;
    bit         cur_flag  = 0;
    int         exp_seq   = 0;
    int         exp_pos [2]  = '{0, 0};
    int         full_cnt [2] = '{0, 0};
    int         snap [2]     = '{0, 0};
    int         rd_cnt [2]   = '{0, 0};
    int         overlap  = 0;
    int         act_err  = 0;
    int         pkt_done = 0;

    task automatic finish_pkt();
        int errs;
        int other;
        errs  = 0;
        other = 1 - cur_ch;
        check_val("pkt_len", 32'(pkt.size()), 32'(HDR_LEN()));
        if (pkt.size() >= 8) begin
            check_val("hdr_magic", {16'd0, pkt[0], pkt[1]}, {16'd0, MAG});
            check_val("hdr_chan", {24'd0, pkt[2]}, 32'(cur_ch));
            check_val("hdr_flags", {24'd0, pkt[3]}, {31'd0, cur_flag});
            check_val("hdr_seq", {pkt[4], pkt[5], pkt[6], pkt[7]}, 32'(exp_seq));
        end
        for (int i = 0; i < N; i++) begin
            if ((8 + i) >= pkt.size()) errs++;
            else if (pkt[8 + i] !== stream[cur_ch][(exp_pos[cur_ch] + i) % SLEN]) errs++;
        end
        check_val("payload_errs", 32'(errs), 32'd0);
        check_val("rd_sel_cycles", 32'(rd_cnt[cur_ch]), 32'(N));
        check_val("rd_other_cycles", 32'(rd_cnt[other]), 32'd0);
        check_val("rd_overlap", 32'(overlap), 32'd0);
        check_val("active_vs_valid", 32'(act_err), 32'd0);
        check_val("seq_after_pkt", seq_num, 32'(exp_seq + 1));
        exp_seq++;
        exp_pos[cur_ch] += N;
        ptr_m    = other;
        rd_cnt   = '{0, 0};
        overlap  = 0;
        act_err  = 0;
        pkt.delete();
        pkt_done++;
    endtask

    function automatic int HDR_LEN();
        return 8 + N;
    endfunction

    task automatic monitor();
        logic [1:0] av;
        if (!rstn) begin
            pkt.delete();
            in_pkt    = 0;
            have_prev = 0;
            gap       = 0;
            exp_seq   = 0;
            ptr_m     = 0;
            snap      = full_cnt;
            exp_pos   = rp;
            rd_cnt    = '{0, 0};
            overlap   = 0;
            act_err   = 0;
            return;
        end
        if (rd_en1 && rd_en2) overlap++;
        if (active !== udp_tx_valid) act_err++;
        if (udp_tx_valid) begin
            if (!in_pkt) begin
                in_pkt = 1;
                av     = {avail2, avail1};
                cur_ch = av[ptr_m] ? ptr_m : 1 - ptr_m;
                if (have_prev) check_val("ifg_min", 32'(gap >= IFG), 32'd1);
            end
            pkt.push_back(udp_tx_data);
            if (pkt.size() == 4) begin
                cur_flag     = (full_cnt[cur_ch] != snap[cur_ch]);
                snap[cur_ch] = full_cnt[cur_ch];
            end
        end else if (in_pkt) begin
            finish_pkt();
            in_pkt    = 0;
            have_prev = 1;
            gap       = 1;
        end else begin
            gap++;
        end
        if (rd_en1) rd_cnt[0]++;
        if (rd_en2) rd_cnt[1]++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) begin
            if (full1) full_cnt[0]++;
            if (full2) full_cnt[1]++;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_pkts(input int n, input bit rnd_full);
        int target;
        int budget;
        target = pkt_done + n;
        budget = n * (N + 60) + 400;
        while (pkt_done < target && budget > 0) begin
            if (rnd_full) begin
                full1 = ($urandom_range(0, 149) == 0);
                full2 = ($urandom_range(0, 149) == 0);
            end
            tick();
            budget--;
        end
        full1 = 1'b0;
        full2 = 1'b0;
        if (pkt_done < target) check_val("pkt_timeout", 32'(pkt_done), 32'(target));
    endtask

    task automatic wait_cond_size(input int ch_req, input int size_req);
        int budget;
        budget = 3 * (N + 60);
        while (!(in_pkt && (ch_req < 0 || cur_ch == ch_req) && pkt.size() == size_req) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check_val("wait_timeout", 32'(pkt.size()), 32'(size_req));
    endtask

    initial begin
        int n;
        int cnt_hi;
        int hold;
        rstn = 1'b0; en = 1'b0; avail1 = 1'b0; avail2 = 1'b0;
        full1 = 1'b0; full2 = 1'b0; busy = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < SLEN; i++) stream[c][i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_val("rst_valid", 32'(udp_tx_valid), 32'd0);
        check_val("rst_data", 32'(udp_tx_data), 32'd0);
        check_val("rst_rd_en1", 32'(rd_en1), 32'd0);
        check_val("rst_rd_en2", 32'(rd_en2), 32'd0);
        check_val("rst_seq", seq_num, 32'd0);
        check_val("rst_active", 32'(active), 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Single channel.
        avail1 = 1'b1; en = 1'b1;
        wait_pkts(1, 0);

        // Both channels with random overflow pulses.
        avail2 = 1'b1;
        wait_pkts(4, 1);

        // Overflow pulse ahead of a ch1 packet, then in a ch1 flags cycle.
        wait_cond_size(0, 20);
        full2 = 1'b1; tick(); full2 = 1'b0;
        wait_pkts(4, 0);
        wait_cond_size(1, 4);
        full2 = 1'b1; tick(); full2 = 1'b0;
        wait_pkts(3, 0);

        // Busy hold-off.
        wait_cond_size(-1, 30);
        wait_pkts(1, 0);
        busy = 1'b1;
        hold = IFG + $urandom_range(20, 120);
        cnt_hi = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (udp_tx_valid || rd_en1 || rd_en2) cnt_hi++;
        end
        check_val("busy_hold_quiet", 32'(cnt_hi), 32'd0);
        busy = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!udp_tx_valid && n < 6);
        check_val("busy_release_lat", 32'(udp_tx_valid && n <= 2), 32'd1);
        wait_pkts(1, 0);

        // Enable dropped at payload byte 100.
        wait_cond_size(-1, 8 + 101);
        en = 1'b0;
        wait_pkts(1, 0);
        cnt_hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (udp_tx_valid || rd_en1 || rd_en2) cnt_hi++;
        end
        check_val("en_low_quiet", 32'(cnt_hi), 32'd0);
        en = 1'b1;
        wait_pkts(1, 0);

        // Reset at payload byte 500.
        wait_cond_size(-1, 8 + 501);
        #2 rstn = 1'b0;
        #1;
        check_val("arst_valid", 32'(udp_tx_valid), 32'd0);
        check_val("arst_rd_en1", 32'(rd_en1), 32'd0);
        check_val("arst_rd_en2", 32'(rd_en2), 32'd0);
        check_val("arst_seq", seq_num, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        wait_pkts(2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
